// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular multiplier.
//   RSA_WIDTH_DEF : default operand/modulus width in bits
//   rsa_state_t   : controller state encoding
package rsa_pkg;

    localparam int RSA_WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } rsa_state_t;

endpackage

// File: rtl/rsa_modstep.sv
// One Blakley interleaved step: r_next = (2*r + a_bit*b) mod n.
// Ports:
//   r      : current partial result, already reduced (r < n)
//   a_bit  : current multiplier bit
//   b      : multiplicand (b < n)
//   n      : modulus
//   r_next : reduced partial result
module rsa_modstep
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] r,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] r_next
);

    localparam int XW = WIDTH + 2;

    logic [XW-1:0] n_x;
    logic [XW-1:0] t0;
    logic [XW-1:0] t1;

    // 2r + b < 3n < 2^(WIDTH+2), so two extra bits hold the sum without loss
    // and at most two subtractions of n bring it back below n.
    always_comb begin
        n_x = {2'b00, n};
        t0  = {1'b0, r, 1'b0} + (a_bit ? {2'b00, b} : '0);
        t1  = (t0 >= n_x) ? (t0 - n_x) : t0;
        // after the second subtraction the value is below n, so WIDTH bits suffice
        r_next = (t1 >= n_x) ? WIDTH'(t1 - n_x) : t1[WIDTH-1:0];
    end

endmodule

// File: rtl/rsa_modmult.sv
// Sequential modular multiplier: result = (a*b) mod n, one bit of a per cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only in IDLE
//   a, b, n  : operands and modulus, captured on the accepting edge
//   busy     : high in CALC and DONE
//   done     : one-cycle pulse, result/err valid
//   err      : operand error (n==0, a>=n or b>=n)
//   result   : (a*b) mod n, held until the next accepted start
//
// state | meaning
// IDLE  | waiting for start
// CALC  | processing one bit of a per cycle, MSB first
// DONE  | done pulse, returns to IDLE
module rsa_modmult
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_state_t       state;
    rsa_state_t       state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [IW-1:0]    idx;
    logic             op_bad;

    assign op_bad = (n == '0) || (a >= n) || (b >= n);

    rsa_modstep #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (acc),
        .a_bit  (a_q[idx]),
        .b      (b_q),
        .n      (n_q),
        .r_next (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = op_bad ? DONE : CALC;
                end
            end
            CALC: begin
                if (idx == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        result <= '0;
                        if (op_bad) begin
                            err <= 1'b1;
                        end else begin
                            err <= 1'b0;
                            a_q <= a;
                            b_q <= b;
                            n_q <= n;
                            acc <= '0;
                            idx <= IW'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        result <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

endmodule
